// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: UART command controller that turns received byte frames into
// register-file accesses (single and burst) and ALU operations, returning results to TX.
module sys_ctrl_burst #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_OUT_BYTES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [DATA_WIDTH-1:0]               RX_P_Data,
  input  logic                                RX_Data_Valid,
  input  logic [DATA_WIDTH-1:0]               RdData,
  input  logic                                RdData_Valid,
  input  logic [DATA_WIDTH*ALU_OUT_BYTES-1:0] ALU_OUT,
  input  logic                                ALU_OUT_Valid,
  input  logic                                TX_Busy,
  output logic                                ALU_EN,
  output logic [3:0]                          ALU_FUN,
  output logic                                ALU_CLK_EN,
  output logic [ADDR_WIDTH-1:0]               Address,
  output logic                                WrEN,
  output logic                                RdEN,
  output logic [DATA_WIDTH-1:0]               WrData,
  output logic [DATA_WIDTH-1:0]               TX_P_Data,
  output logic                                TX_Data_Valid,
  output logic                                clk_div_en,
  output logic                                rx_drop
);

  localparam int RES_W = DATA_WIDTH * ALU_OUT_BYTES;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W = $clog2(ALU_OUT_BYTES + 1);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_LEN, GET_WDATA, RD_REQ, RD_WAIT, RD_SEND,
    GET_A, GET_B, GET_FUN, ALU_REQ, ALU_WAIT, ALU_SEND, ERR_SEND
  } state_t;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_BWR, OP_BRD} op_t;

  state_t                  state;
  op_t                     op;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   len;
  logic [TO_W-1:0]         to_cnt;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [DATA_WIDTH-1:0]   err_code;
  logic [RES_W-1:0]        result;
  logic [IDX_W-1:0]        byte_idx;

  function automatic logic is_get(input state_t s);
    return (s == GET_ADDR) || (s == GET_LEN) || (s == GET_WDATA) ||
           (s == GET_A) || (s == GET_B) || (s == GET_FUN);
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      op            <= OP_WR;
      addr          <= '0;
      len           <= '0;
      to_cnt        <= '0;
      rd_data       <= '0;
      err_code      <= '0;
      result        <= '0;
      byte_idx      <= '0;
      ALU_EN        <= 1'b0;
      ALU_FUN       <= '0;
      ALU_CLK_EN    <= 1'b0;
      Address       <= '0;
      WrEN          <= 1'b0;
      RdEN          <= 1'b0;
      WrData        <= '0;
      TX_P_Data     <= '0;
      TX_Data_Valid <= 1'b0;
      clk_div_en    <= 1'b0;
      rx_drop       <= 1'b0;
    end else begin
      WrEN          <= 1'b0;
      RdEN          <= 1'b0;
      ALU_EN        <= 1'b0;
      TX_Data_Valid <= 1'b0;
      rx_drop       <= 1'b0;

      case (state)
        IDLE: if (RX_Data_Valid) begin
          case (RX_P_Data)
            DATA_WIDTH'(8'hAA): begin op <= OP_WR;  state <= GET_ADDR; end
            DATA_WIDTH'(8'hBB): begin op <= OP_RD;  state <= GET_ADDR; end
            DATA_WIDTH'(8'hEE): begin op <= OP_BWR; state <= GET_ADDR; end
            DATA_WIDTH'(8'hEF): begin op <= OP_BRD; state <= GET_ADDR; end
            DATA_WIDTH'(8'hCC): state <= GET_A;
            DATA_WIDTH'(8'hDD): state <= GET_FUN;
            default: begin
              err_code <= DATA_WIDTH'(8'hF1);
              state    <= ERR_SEND;
            end
          endcase
        end

        GET_ADDR: if (RX_Data_Valid) begin
          addr <= RX_P_Data[ADDR_WIDTH-1:0];
          case (op)
            OP_WR: begin len <= DATA_WIDTH'(1); state <= GET_WDATA; end
            OP_RD: begin
              len     <= DATA_WIDTH'(1);
              Address <= RX_P_Data[ADDR_WIDTH-1:0];
              RdEN    <= 1'b1;
              state   <= RD_REQ;
            end
            default: state <= GET_LEN;
          endcase
        end

        // A zero-length burst is rejected before any RF access is issued.
        GET_LEN: if (RX_Data_Valid) begin
          if (RX_P_Data == '0) begin
            err_code <= DATA_WIDTH'(8'hF2);
            state    <= ERR_SEND;
          end else begin
            len <= RX_P_Data;
            if (op == OP_BWR) begin
              state <= GET_WDATA;
            end else begin
              Address <= addr;
              RdEN    <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end

        GET_WDATA: if (RX_Data_Valid) begin
          WrEN    <= 1'b1;
          Address <= addr;
          WrData  <= RX_P_Data;
          addr    <= addr + ADDR_WIDTH'(1);
          len     <= len - DATA_WIDTH'(1);
          if (len == DATA_WIDTH'(1)) state <= IDLE;
        end

        RD_REQ: state <= RD_WAIT;

        RD_WAIT: if (RdData_Valid) begin
          rd_data <= RdData;
          state   <= RD_SEND;
        end

        // The next read of a burst is only requested once this byte is pushed.
        RD_SEND: if (!TX_Busy) begin
          TX_Data_Valid <= 1'b1;
          TX_P_Data     <= rd_data;
          clk_div_en    <= 1'b1;
          len           <= len - DATA_WIDTH'(1);
          if (len == DATA_WIDTH'(1)) begin
            state <= IDLE;
          end else begin
            addr    <= addr + ADDR_WIDTH'(1);
            Address <= addr + ADDR_WIDTH'(1);
            RdEN    <= 1'b1;
            state   <= RD_REQ;
          end
        end

        GET_A: if (RX_Data_Valid) begin
          WrEN    <= 1'b1;
          Address <= '0;
          WrData  <= RX_P_Data;
          state   <= GET_B;
        end

        GET_B: if (RX_Data_Valid) begin
          WrEN    <= 1'b1;
          Address <= ADDR_WIDTH'(1);
          WrData  <= RX_P_Data;
          state   <= GET_FUN;
        end

        GET_FUN: if (RX_Data_Valid) begin
          ALU_FUN    <= RX_P_Data[3:0];
          ALU_EN     <= 1'b1;
          ALU_CLK_EN <= 1'b1;
          state      <= ALU_REQ;
        end

        ALU_REQ: state <= ALU_WAIT;

        ALU_WAIT: if (ALU_OUT_Valid) begin
          result   <= ALU_OUT;
          byte_idx <= '0;
          state    <= ALU_SEND;
        end

        // Result is shifted down so the next byte to send is always at the bottom.
        ALU_SEND: if (!TX_Busy) begin
          TX_Data_Valid <= 1'b1;
          TX_P_Data     <= result[DATA_WIDTH-1:0];
          clk_div_en    <= 1'b1;
          result        <= result >> DATA_WIDTH;
          byte_idx      <= byte_idx + IDX_W'(1);
          if (byte_idx == IDX_W'(ALU_OUT_BYTES - 1)) begin
            ALU_CLK_EN <= 1'b0;
            state      <= IDLE;
          end
        end

        ERR_SEND: if (!TX_Busy) begin
          TX_Data_Valid <= 1'b1;
          TX_P_Data     <= err_code;
          clk_div_en    <= 1'b1;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Inter-byte timeout runs only while a frame is being collected.
      if (is_get(state)) begin
        if (RX_Data_Valid) begin
          to_cnt <= '0;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          to_cnt   <= '0;
          err_code <= DATA_WIDTH'(8'hF3);
          state    <= ERR_SEND;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end else begin
        to_cnt <= '0;
      end

      if (RX_Data_Valid && !((state == IDLE) || is_get(state))) rx_drop <= 1'b1;
    end
  end

endmodule
